mfcc_feature_buffer: RTL

// - Downstream consumer of the DCT stage: takes the per-frame stream of N signed Q_D cepstral values,

---
 rtl/mfcc_feature_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mfcc_feature_buffer.sv
// MFCC feature buffer: keeps the first NUM_CEPS DCT coefficients of each
// frame in a NUM_FRAMES-deep ring and streams the window on request.
module mfcc_feature_buffer #(
    parameter int Q_D        = 4,
    parameter int N          = 32,
    parameter int NUM_CEPS   = 13,
    parameter int NUM_FRAMES = 49
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [Q_D-1:0] dct_in,
    input  logic                  dct_valid,
    input  logic                  start_readout,
    output logic signed [Q_D-1:0] feat_out,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic                  feat_last,
    output logic                  window_full,
    output logic                  frame_dropped
);

    localparam int DEPTH = NUM_FRAMES * NUM_CEPS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int FW    = $clog2(NUM_FRAMES + 1);

    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] A_STEP = AW'(NUM_CEPS);
    localparam logic [AW-1:0] A_TOP  = AW'(DEPTH - NUM_CEPS);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [FW-1:0] F_FULL = FW'(NUM_FRAMES);

    typedef enum logic [1:0] {S_WRITE, S_PEND, S_READ} state_t;

    state_t                r_state;
    logic [KW-1:0]         r_k;
    logic                  r_drop;
    logic [AW-1:0]         r_wr_base;
    logic [AW-1:0]         r_rd_addr;
    logic [AW-1:0]         r_rd_cnt;
    logic [FW-1:0]         r_fcnt;
    logic                  r_full;
    logic                  r_more;
    logic                  r_valid;
    logic                  r_last;
    logic signed [Q_D-1:0] r_out;
    logic signed [Q_D-1:0] r_mem [DEPTH];

    logic          w_k0;
    logic          w_enter;
    logic          w_drop;
    logic          w_k_last;
    logic          w_commit;
    logic          w_wr_en;
    logic          w_to_read;
    logic          w_accept;
    logic          w_load;
    logic [AW-1:0] w_wr_base_nxt;

    // A frame that starts while the window is (or is about to be) read is
    // discarded so the ring under readout is never overwritten.
    assign w_k0     = (r_k == '0);
    assign w_enter  = (r_state == S_WRITE) && start_readout && r_full && w_k0;
    assign w_drop   = w_k0 ? ((r_state == S_READ) || w_enter) : r_drop;
    assign w_k_last = dct_valid && (r_k == K_LAST);
    assign w_commit = w_k_last && !w_drop;
    assign w_wr_en  = dct_valid && !w_drop && (int'(r_k) < NUM_CEPS);

    assign w_wr_base_nxt = !w_commit ? r_wr_base :
                           (r_wr_base == A_TOP) ? '0 : r_wr_base + A_STEP;

    assign w_to_read = w_enter || ((r_state == S_PEND) && w_k_last);
    assign w_accept  = r_valid && feat_ready;
    assign w_load    = (r_state == S_READ) && r_more && (!r_valid || feat_ready);

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_base + AW'(r_k)] <= dct_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_WRITE;
            r_k       <= '0;
            r_drop    <= 1'b0;
            r_wr_base <= '0;
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_fcnt    <= '0;
            r_full    <= 1'b0;
            r_more    <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_out     <= '0;
        end else begin
            if (dct_valid) begin
                r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                if (w_k0) r_drop <= w_drop;
            end
            r_wr_base <= w_wr_base_nxt;
            if (w_commit && (r_fcnt != F_FULL)) r_fcnt <= r_fcnt + 1'b1;
            if (w_commit && (r_fcnt == F_FULL - FW'(1))) r_full <= 1'b1;

            unique case (r_state)
                S_WRITE: if (start_readout && r_full)
                             r_state <= w_k0 ? S_READ : S_PEND;
                S_PEND:  if (w_k_last) r_state <= S_READ;
                S_READ:  if (w_accept && r_last) r_state <= S_WRITE;
                default: r_state <= S_WRITE;
            endcase

            // Oldest frame is the one the next commit would overwrite.
            if (w_to_read) begin
                r_rd_addr <= w_wr_base_nxt;
                r_rd_cnt  <= '0;
                r_more    <= 1'b1;
            end

            if (w_load) begin
                r_out     <= r_mem[r_rd_addr];
                r_valid   <= 1'b1;
                r_last    <= (r_rd_cnt == A_LAST);
                r_rd_addr <= (r_rd_addr == A_LAST) ? '0 : r_rd_addr + 1'b1;
                r_rd_cnt  <= r_rd_cnt + 1'b1;
                if (r_rd_cnt == A_LAST) r_more <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign feat_out      = r_out;
    assign feat_valid    = r_valid;
    assign feat_last     = r_last;
    assign window_full   = r_full;
    assign frame_dropped = !rst && w_k_last && w_drop;

endmodule
